// File: rtl/mips_hazard_pkg.sv
// Shared encodings and latency constants for the MIPS scoreboard hazard unit.
package mips_hazard_pkg;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_MUL  = 2'd2
  } cls_e;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

  // A decode-stage consumer needs the value already in the bypass (cnt == 0);
  // an E-stage consumer can tolerate one more cycle.
  localparam int THR_EARLY = 0;
  localparam int THR_LATE  = 1;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard countdown: clear beats load, load beats decrement, stops at zero.
module sb_entry #(
  parameter int CW = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic [CW-1:0] i_val,
  output logic [CW-1:0] o_cnt
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                r_cnt <= '0;
    else if (i_clr)           r_cnt <= '0;
    else if (i_load)          r_cnt <= i_val;
    else if (r_cnt != '0)     r_cnt <= r_cnt - CW'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit: per-register countdowns drive F/D stall and D/E flush.
// HAZ_MUL_EN enables the multi-cycle MUL class and its structural hazard.
module hazard_scoreboard
  import mips_hazard_pkg::*;
#(
  parameter int NREG    = 32,
  parameter int RW      = $clog2(NREG),
  parameter int LAT_MUL = 4,
  parameter int CW      = ($clog2(LAT_MUL + 1) < 2) ? 2 : $clog2(LAT_MUL + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_d,
  input  logic [RW-1:0] rs_d,
  input  logic [RW-1:0] rt_d,
  input  logic          use_rs_d,
  input  logic          use_rt_d,
  input  logic          early_d,
  input  logic          wr_en_d,
  input  logic [RW-1:0] wr_reg_d,
  input  logic [1:0]    class_d,
  input  logic          kill,
  output logic          stall_f,
  output logic          stall_d,
  output logic          flush_e,
  output logic          mul_busy,
  output logic [31:0]   stall_count
);

  logic [CW-1:0] w_cnt [NREG];
  logic [CW-1:0] w_thr;
  logic [CW-1:0] w_lat;
  logic          w_need_rs, w_need_rt;
  logic          w_dstall, w_sstall, w_stall;
  logic          w_issue, w_wr;
  logic [31:0]   r_stall_count;

  assign w_cnt[0] = '0;

  assign w_thr     = early_d ? CW'(THR_EARLY) : CW'(THR_LATE);
  assign w_need_rs = use_rs_d && (rs_d != '0) && (w_cnt[rs_d] > w_thr);
  assign w_need_rt = use_rt_d && (rt_d != '0) && (w_cnt[rt_d] > w_thr);
  assign w_dstall  = issue_d && (w_need_rs || w_need_rt);
  assign w_stall   = w_dstall || w_sstall;
  assign w_issue   = issue_d && !w_stall;
  assign w_wr      = w_issue && wr_en_d && (wr_reg_d != '0);

  always_comb begin
    w_lat = CW'(LAT_ALU);
    case (class_d)
      CLS_LOAD: w_lat = CW'(LAT_LOAD);
`ifdef HAZ_MUL_EN
      CLS_MUL:  w_lat = CW'(LAT_MUL);
`endif
      default:  ;
    endcase
  end

  for (genvar g = 1; g < NREG; g++) begin : g_ent
    sb_entry #(.CW(CW)) u_ent (
      .i_clk  (clk),
      .i_rst  (reset),
      .i_clr  (kill),
      .i_load (w_wr && (wr_reg_d == RW'(g))),
      .i_val  (w_lat),
      .o_cnt  (w_cnt[g])
    );
  end

`ifdef HAZ_MUL_EN
  logic [CW-1:0] r_mul_timer;

  // The timer is claimed by any issued MUL, even one that writes no register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              r_mul_timer <= '0;
    else if (kill)                          r_mul_timer <= '0;
    else if (w_issue && class_d == CLS_MUL) r_mul_timer <= CW'(LAT_MUL);
    else if (r_mul_timer != '0)             r_mul_timer <= r_mul_timer - CW'(1);
  end

  assign mul_busy = r_mul_timer > CW'(1);
  assign w_sstall = issue_d && (class_d == CLS_MUL) && mul_busy;
`else
  assign mul_busy = 1'b0;
  assign w_sstall = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             r_stall_count <= '0;
    else if (w_stall && r_stall_count != '1) r_stall_count <= r_stall_count + 32'd1;
  end

  assign stall_f     = w_stall;
  assign stall_d     = w_stall;
  assign flush_e     = w_stall;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized + directed bench for hazard_scoreboard against a ready-time reference model.
module tb_hazard_scoreboard;

  localparam int NREG    = 32;
  localparam int LAT_MUL = 4;
`ifdef HAZ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  localparam logic [1:0] C_ALU = 2'd0, C_LOAD = 2'd1, C_MUL = 2'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue_d = 1'b0, use_rs_d = 1'b0, use_rt_d = 1'b0, early_d = 1'b0;
  logic        wr_en_d = 1'b0, kill = 1'b0;
  logic [4:0]  rs_d = '0, rt_d = '0, wr_reg_d = '0;
  logic [1:0]  class_d = '0;
  logic        stall_f, stall_d, flush_e, mul_busy;
  logic [31:0] stall_count;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NREG(NREG), .LAT_MUL(LAT_MUL)) dut (
    .clk(clk), .reset(reset), .issue_d(issue_d), .rs_d(rs_d), .rt_d(rt_d),
    .use_rs_d(use_rs_d), .use_rt_d(use_rt_d), .early_d(early_d),
    .wr_en_d(wr_en_d), .wr_reg_d(wr_reg_d), .class_d(class_d), .kill(kill),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .mul_busy(mul_busy), .stall_count(stall_count)
  );

  int n_pass = 0, n_total = 0;

  // Model: absolute cycle at which each result reaches the bypass.
  longint cyc = 0;
  longint ready_at [NREG];
  longint mul_done = 0;
  longint m_sc = 0;
  bit     e_stall, e_busy;
  bit     s_stall, s_busy;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  function automatic longint left(input longint t);
    return (t > cyc) ? t - cyc : 0;
  endfunction

  function automatic int lat_of(input logic [1:0] c);
    if (c == C_LOAD) return 2;
    if (c == C_MUL && MUL_EN) return LAT_MUL;
    return 1;
  endfunction

  task automatic model_eval();
    bit need_rs, need_rt, sst;
    if (reset) begin
      foreach (ready_at[i]) ready_at[i] = 0;
      mul_done = 0;
      m_sc = 0;
    end
    need_rs = use_rs_d && rs_d != 0 && left(ready_at[rs_d]) > (early_d ? 0 : 1);
    need_rt = use_rt_d && rt_d != 0 && left(ready_at[rt_d]) > (early_d ? 0 : 1);
    e_busy  = MUL_EN && left(mul_done) > 1;
    sst     = class_d == C_MUL && e_busy;
    e_stall = issue_d && (need_rs || need_rt || sst);
  endtask

  task automatic model_update();
    if (e_stall && m_sc != 64'hFFFF_FFFF) m_sc++;
    if (kill) begin
      foreach (ready_at[i]) ready_at[i] = 0;
      mul_done = 0;
    end else if (issue_d && !e_stall) begin
      if (wr_en_d && wr_reg_d != 0) ready_at[wr_reg_d] = cyc + 1 + lat_of(class_d);
      if (MUL_EN && class_d == C_MUL) mul_done = cyc + 1 + LAT_MUL;
    end
    cyc++;
  endtask

  // Called just after a falling edge with the cycle's inputs already driven.
  task automatic cyc_run();
    #1;
    model_eval();
    s_stall = stall_d;
    s_busy  = mul_busy;
    chk("stall_d",     stall_d,     e_stall);
    chk("stall_f",     stall_f,     e_stall);
    chk("flush_e",     flush_e,     e_stall);
    chk("mul_busy",    mul_busy,    e_busy);
    chk("stall_count", stall_count, m_sc);
    @(posedge clk);
    if (!reset) model_update();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    issue_d = 1'b0;
    kill    = 1'b0;
    repeat (n) cyc_run();
  endtask

  task automatic issue_op(input logic [1:0] cls, input logic we, input logic [4:0] rd,
                          input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt, input logic early,
                          output int n_st, output int n_busy);
    n_st = 0;
    n_busy = 0;
    issue_d = 1'b1; class_d = cls; wr_en_d = we; wr_reg_d = rd;
    rs_d = rs; use_rs_d = urs; rt_d = rt; use_rt_d = urt; early_d = early;
    for (int k = 0; k < 20; k++) begin
      cyc_run();
      if (s_stall) n_st++;
      if (s_stall && s_busy) n_busy++;
      if (!e_stall) begin
        issue_d = 1'b0;
        return;
      end
    end
    issue_d = 1'b0;
    chk("issue_timeout", 1, 0);
  endtask

  initial begin
    int     st, bz;
    longint sc0;
    @(negedge clk);
    cyc_run();
    reset = 1'b0;
    idle(2);

    // ALU producer: late consumer free, early consumer one bubble
    issue_op(C_ALU, 1, 8, 1, 1, 2, 1, 0, st, bz);
    issue_op(C_ALU, 1, 3, 8, 1, 0, 0, 0, st, bz);
    chk("alu_then_alu", st, 0);
    idle(4);
    issue_op(C_ALU, 1, 8, 1, 1, 2, 1, 0, st, bz);
    issue_op(C_ALU, 0, 0, 8, 1, 0, 0, 1, st, bz);
    chk("alu_then_beq", st, 1);
    idle(4);

    sc0 = m_sc;
    issue_op(C_LOAD, 1, 9, 1, 1, 0, 0, 0, st, bz);
    issue_op(C_ALU, 1, 4, 2, 1, 9, 1, 0, st, bz);
    chk("load_then_alu", st, 1);
    chk("load_alu_count", m_sc - sc0, 1);
    idle(4);
    sc0 = m_sc;
    issue_op(C_LOAD, 1, 9, 1, 1, 0, 0, 0, st, bz);
    issue_op(C_ALU, 0, 0, 9, 1, 3, 1, 1, st, bz);
    chk("load_then_beq", st, 2);
    chk("load_beq_count", m_sc - sc0, 2);
    idle(4);

    issue_op(C_MUL, 1, 10, 1, 1, 2, 1, 0, st, bz);
    issue_op(C_ALU, 1, 5, 10, 1, 0, 0, 0, st, bz);
    chk("mul_then_alu", st, MUL_EN ? 3 : 0);
    idle(6);
    issue_op(C_MUL, 1, 10, 1, 1, 2, 1, 0, st, bz);
    issue_op(C_ALU, 0, 0, 10, 1, 0, 0, 1, st, bz);
    chk("mul_then_jr", st, MUL_EN ? 4 : 1);
    idle(6);
    issue_op(C_MUL, 1, 13, 1, 1, 2, 1, 0, st, bz);
    issue_op(C_MUL, 1, 14, 3, 1, 4, 1, 0, st, bz);
    chk("mul_mul_stalls", st, MUL_EN ? 3 : 0);
    chk("mul_mul_busy", bz, MUL_EN ? 3 : 0);
    idle(6);

    issue_op(C_LOAD, 1, 0, 1, 1, 0, 0, 0, st, bz);
    issue_op(C_ALU, 0, 0, 0, 1, 0, 1, 1, st, bz);
    chk("reg0_never_busy", st, 0);
    idle(4);

    issue_op(C_MUL, 1, 11, 1, 1, 0, 0, 0, st, bz);
    kill = 1'b1;
    cyc_run();
    kill = 1'b0;
    issue_op(C_ALU, 0, 0, 11, 1, 0, 0, 1, st, bz);
    chk("kill_then_dep", st, 0);
    idle(2);

    issue_op(C_MUL, 1, 11, 1, 1, 0, 0, 0, st, bz);
    reset = 1'b1;
    cyc_run();
    reset = 1'b0;
    #1 chk("count_after_reset", stall_count, 0);
    issue_op(C_ALU, 0, 0, 11, 1, 0, 0, 1, st, bz);
    chk("reset_then_dep", st, 0);
    idle(4);

    issue_op(C_LOAD, 1, 12, 1, 1, 0, 0, 0, st, bz);
    issue_op(C_ALU, 1, 12, 1, 1, 0, 0, 0, st, bz);
    chk("waw_second_issue", st, 0);
    issue_op(C_ALU, 1, 6, 12, 1, 0, 0, 0, st, bz);
    chk("waw_dep_alu", st, 0);
    idle(6);
    issue_op(C_MUL, 1, 12, 1, 1, 0, 0, 0, st, bz);
    issue_op(C_ALU, 1, 12, 1, 1, 0, 0, 0, st, bz);
    issue_op(C_ALU, 0, 0, 12, 1, 0, 0, 1, st, bz);
    chk("waw_shorter_wins", st, 1);
    idle(6);

    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 199) == 0);
      kill     = ($urandom_range(0, 31) == 0);
      issue_d  = ($urandom_range(0, 3) != 0);
      rs_d     = 5'($urandom_range(0, 7));
      rt_d     = 5'($urandom_range(0, 7));
      wr_reg_d = 5'($urandom_range(0, 7));
      use_rs_d = 1'($urandom_range(0, 1));
      use_rt_d = 1'($urandom_range(0, 1));
      early_d  = ($urandom_range(0, 3) == 0);
      wr_en_d  = ($urandom_range(0, 3) != 0);
      class_d  = 2'($urandom_range(0, 3));
      cyc_run();
    end
    reset = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
